// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - programmable serial bit-pattern detector (optional DET_COUNT_EN match counter)
module seq_detector_param #(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 16,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(8'h0D),
  parameter int               RST_LEN = 4,
  parameter bit               RST_OVL = 1'b0,
  localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data,
  input  logic             valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             detected
`ifdef DET_COUNT_EN
  ,
  output logic [CNT_W-1:0] det_count
`endif
);

  // Reject configurations the window shift or counter cannot represent.
  if (PAT_W < 2 || CNT_W < 1) begin : g_param_check
    $error("seq_detector_param: PAT_W must be >= 2 and CNT_W >= 1");
  end

  logic [PAT_W-1:0] pat;
  logic [LEN_W-1:0] len;
  logic             ovl;
  logic [PAT_W-1:0] win;
  logic [LEN_W-1:0] fill;

  logic [PAT_W-1:0] win_n;
  logic [LEN_W-1:0] fill_n;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len_clamped;
  logic             match;

  // Next window/fill and the match decision for the bit presented this cycle.
  always_comb begin
    win_n       = {win[PAT_W-2:0], data};
    fill_n      = (fill >= LEN_W'(PAT_W)) ? fill : fill + 1'b1;
    mask        = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (i < int'(len));
    end
    // A match needs at least len bits since the last flush and the newest len bits equal to the pattern.
    match       = (len != '0) && (fill_n >= len) && (((win_n ^ pat) & mask) == '0);
    len_clamped = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
  end

  // Active configuration, replaced wholesale on cfg_load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat <= RST_PAT;
      len <= LEN_W'(RST_LEN);
      ovl <= RST_OVL;
    end else if (cfg_load) begin
      pat <= cfg_pattern;
      len <= len_clamped;
      ovl <= cfg_overlap;
    end
  end

  // Shift window, fill counter and registered match pulse; cfg_load flushes progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win      <= '0;
      fill     <= '0;
      detected <= 1'b0;
    end else if (cfg_load) begin
      win      <= '0;
      fill     <= '0;
      detected <= 1'b0;
    end else if (valid) begin
      win      <= win_n;
      // Non-overlapping mode restarts the count so no matched bit can be reused.
      fill     <= (match && !ovl) ? '0 : fill_n;
      detected <= match;
    end else begin
      detected <= 1'b0;
    end
  end

`ifdef DET_COUNT_EN
  // Saturating match counter, cleared by a configuration load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_count <= '0;
    end else if (cfg_load) begin
      det_count <= '0;
    end else if (valid && match && (det_count != {CNT_W{1'b1}})) begin
      det_count <= det_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - self-checking bench for seq_detector_param
module tb_seq_detector_param;

  localparam int CNT_W = 2;

  logic       clk;
  logic       reset;
  logic       data;
  logic       valid;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       detected;
`ifdef DET_COUNT_EN
  logic [CNT_W-1:0] det_count;
`endif

  seq_detector_param #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset(reset),
    .data(data),
    .valid(valid),
    .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
    .detected(detected)
`ifdef DET_COUNT_EN
    ,
    .det_count(det_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int total  = 0;

  // Reference model: history of accepted bits since the last flush.
  bit       hist[$];
  bit [7:0] m_pat;
  int       m_len;
  bit       m_ovl;
  bit       m_det;
  int       m_cnt;

  function automatic void model_reset();
    hist.delete();
    m_pat = 8'h0D;
    m_len = 4;
    m_ovl = 1'b0;
    m_det = 1'b0;
    m_cnt = 0;
  endfunction

  function automatic void model_step(bit v, bit d, bit ld, bit [7:0] cp, bit [3:0] cl, bit co);
    bit hit;
    if (ld) begin
      m_pat = cp;
      m_len = (cl > 8) ? 8 : int'(cl);
      m_ovl = co;
      hist.delete();
      m_det = 1'b0;
      m_cnt = 0;
    end else if (v) begin
      hist.push_back(d);
      hit = (m_len > 0) && (hist.size() >= m_len);
      for (int i = 0; i < m_len && hit; i++) begin
        if (hist[hist.size() - 1 - i] != m_pat[i]) hit = 1'b0;
      end
      m_det = hit;
      if (hit) begin
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!m_ovl) hist.delete();
      end
      while (hist.size() > 8) void'(hist.pop_front());
    end else begin
      m_det = 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic v, input logic d, input logic ld,
                       input logic [7:0] cp, input logic [3:0] cl, input logic co);
    valid = v; data = d; cfg_load = ld;
    cfg_pattern = cp; cfg_len = cl; cfg_overlap = co;
    @(posedge clk);
    model_step(v, d, ld, cp, cl, co);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic       d;
    logic       ld;
    logic [7:0] cp;
    logic [3:0] cl;
    logic       co;
    logic       exp_det;
    int         exp_cnt;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t bt(logic d, logic e, int c);
    vec_t r = '{v: 1'b1, d: d, ld: 1'b0, cp: 8'h00, cl: 4'd0, co: 1'b0, exp_det: e, exp_cnt: c};
    return r;
  endfunction

  function automatic vec_t gap(int c);
    vec_t r = '{v: 1'b0, d: 1'b1, ld: 1'b0, cp: 8'h00, cl: 4'd0, co: 1'b0, exp_det: 1'b0, exp_cnt: c};
    return r;
  endfunction

  function automatic vec_t ldv(logic [7:0] cp, logic [3:0] cl, logic co);
    vec_t r = '{v: 1'b1, d: 1'b1, ld: 1'b1, cp: cp, cl: cl, co: co, exp_det: 1'b0, exp_cnt: 0};
    return r;
  endfunction

  initial begin
    reset = 1'b1; data = 1'b0; valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    model_reset();

    // Default 1101 non-overlap: match at bit 4 only.
    tab.push_back(bt(1,0,0)); tab.push_back(bt(1,0,0)); tab.push_back(bt(0,0,0));
    tab.push_back(bt(1,1,1)); tab.push_back(bt(1,0,1)); tab.push_back(bt(0,0,1));
    tab.push_back(bt(1,0,1));
    // 101 overlapping.
    tab.push_back(ldv(8'h05, 4'd3, 1'b1));
    tab.push_back(bt(1,0,0)); tab.push_back(bt(0,0,0)); tab.push_back(bt(1,1,1));
    tab.push_back(bt(0,0,1)); tab.push_back(bt(1,1,2));
    // 101 non-overlapping.
    tab.push_back(ldv(8'h05, 4'd3, 1'b0));
    tab.push_back(bt(1,0,0)); tab.push_back(bt(0,0,0)); tab.push_back(bt(1,1,1));
    tab.push_back(bt(0,0,1)); tab.push_back(bt(1,0,1));
    // 1101 with valid gaps between bits.
    tab.push_back(ldv(8'h0D, 4'd4, 1'b0));
    tab.push_back(bt(1,0,0)); tab.push_back(gap(0)); tab.push_back(bt(1,0,0));
    tab.push_back(gap(0)); tab.push_back(bt(0,0,0)); tab.push_back(gap(0));
    tab.push_back(bt(1,1,1)); tab.push_back(gap(1));
    // Full-width pattern A5, then disabled, then clamped length 9.
    for (int k = 0; k < 3; k++) begin
      tab.push_back(ldv(8'hA5, (k == 0) ? 4'd8 : (k == 1) ? 4'd0 : 4'd9, 1'b0));
      tab.push_back(bt(1,0,0)); tab.push_back(bt(0,0,0)); tab.push_back(bt(1,0,0));
      tab.push_back(bt(0,0,0)); tab.push_back(bt(0,0,0)); tab.push_back(bt(1,0,0));
      tab.push_back(bt(0,0,0)); tab.push_back(bt(1, (k != 1), (k != 1) ? 1 : 0));
    end
    // len=1 overlapping: back-to-back pulses, counter saturates at 3.
    tab.push_back(ldv(8'h01, 4'd1, 1'b1));
    tab.push_back(bt(1,1,1)); tab.push_back(bt(1,1,2)); tab.push_back(bt(1,1,3));
    tab.push_back(bt(1,1,3)); tab.push_back(bt(1,1,3)); tab.push_back(bt(1,1,3));
    tab.push_back(bt(0,0,3));
    tab.push_back(ldv(8'h0D, 4'd4, 1'b0));

    #12;
    check("reset_det", detected, 1'b0);
`ifdef DET_COUNT_EN
    check("reset_cnt", det_count, 0);
`endif
    reset = 1'b0;

    foreach (tab[i]) begin
      drive(tab[i].v, tab[i].d, tab[i].ld, tab[i].cp, tab[i].cl, tab[i].co);
      check($sformatf("tab%0d_det", i), detected, tab[i].exp_det);
`ifdef DET_COUNT_EN
      check($sformatf("tab%0d_cnt", i), det_count, tab[i].exp_cnt);
`endif
    end

    // Async reset clears a live pulse without a clock edge.
    drive(1,1,0,8'h0,4'd0,0); drive(1,1,0,8'h0,4'd0,0);
    drive(1,0,0,8'h0,4'd0,0); drive(1,1,0,8'h0,4'd0,0);
    check("pre_rst_det", detected, 1'b1);
    #2 reset = 1'b1;
    #1 check("async_rst_det", detected, 1'b0);
    model_reset();
    #3 reset = 1'b0;

    // Partial 110 discarded by a mid-cycle reset.
    drive(1,1,0,8'h0,4'd0,0); drive(1,1,0,8'h0,4'd0,0); drive(1,0,0,8'h0,4'd0,0);
    #2 reset = 1'b1;
    model_reset();
    #3 reset = 1'b0;
    drive(1,1,0,8'h0,4'd0,0);
    check("post_rst_1", detected, 1'b0);
    drive(1,1,0,8'h0,4'd0,0); check("post_rst_a", detected, 1'b0);
    drive(1,1,0,8'h0,4'd0,0); check("post_rst_b", detected, 1'b0);
    drive(1,0,0,8'h0,4'd0,0); check("post_rst_c", detected, 1'b0);
    drive(1,1,0,8'h0,4'd0,0); check("post_rst_d", detected, 1'b1);
`ifdef DET_COUNT_EN
    check("post_rst_cnt", det_count, 1);
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      logic       v, d, ld, co;
      logic [7:0] cp;
      logic [3:0] cl;
      v  = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(0, 1);
      ld = ($urandom_range(0, 39) == 0);
      cp = 8'($urandom);
      cl = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      co = $urandom_range(0, 1);
      drive(v, d, ld, cp, cl, co);
      check("rand_det", detected, m_det);
`ifdef DET_COUNT_EN
      check("rand_cnt", det_count, m_cnt);
`endif
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
